// File: rtl/urv_multiply_if.sv
// Decode/execute handshake bundle for the uRV iterative multiplier.
// slave = multiplier side, master = pipeline side.
interface urv_multiply_if;
  logic        x_stall_i;
  logic        x_kill_i;
  logic        x_stall_req_o;
  logic        d_valid_i;
  logic        d_is_multiply_i;
  logic [31:0] d_rs1_i;
  logic [31:0] d_rs2_i;
  logic [2:0]  d_fun_i;
  logic [31:0] x_rd_o;

  modport slave (
    input  x_stall_i, x_kill_i, d_valid_i, d_is_multiply_i,
    input  d_rs1_i, d_rs2_i, d_fun_i,
    output x_stall_req_o, x_rd_o
  );

  modport master (
    output x_stall_i, x_kill_i, d_valid_i, d_is_multiply_i,
    output d_rs1_i, d_rs2_i, d_fun_i,
    input  x_stall_req_o, x_rd_o
  );
endinterface

// File: rtl/urv_multiply.sv
// Iterative radix-2 shift-add 32x32 multiplier (MUL/MULH/MULHSU/MULHU).
// Optional zero-operand shortcut: define URV_MUL_ZERO_BYPASS_EN.
module urv_multiply (
  input  logic          clk_i,
  input  logic          rst_i,
  urv_multiply_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_NEG_A,
    S_NEG_B,
    S_ITER,
    S_RESULT,
    S_DONE
  } state_t;

  // The original 6-bit state counter is split into a phase plus a 5-bit
  // iteration count; cycle-by-cycle timing is unchanged.
  state_t      r_state;
  state_t      w_state_next;
  logic [4:0]  r_iter;

  logic [31:0] r_mcand;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic        r_sign_a;
  logic        r_sign_b;
  logic        r_neg;
  logic        r_is_high;
  logic [31:0] r_rd;

  logic        w_start;
  logic        w_sign_a;
  logic        w_sign_b;
  logic        w_zero_op;
  logic [32:0] w_sum;

  assign w_start  = !bus.x_stall_i && !bus.x_kill_i && bus.d_valid_i && bus.d_is_multiply_i;
  assign w_sign_a = bus.d_rs1_i[31] & ((bus.d_fun_i == 3'd1) | (bus.d_fun_i == 3'd2));
  assign w_sign_b = bus.d_rs2_i[31] & (bus.d_fun_i == 3'd1);

`ifdef URV_MUL_ZERO_BYPASS_EN
  assign w_zero_op = (bus.d_rs1_i == '0) | (bus.d_rs2_i == '0);
`else
  assign w_zero_op = 1'b0;
`endif

  assign w_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_mcand} : 33'd0);

  assign bus.x_stall_req_o = w_start | ((r_state != S_IDLE) & (r_state != S_DONE));
  assign bus.x_rd_o        = r_rd;

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:   if (w_start) w_state_next = w_zero_op ? S_RESULT : S_NEG_A;
      S_NEG_A:  w_state_next = S_NEG_B;
      S_NEG_B:  w_state_next = S_ITER;
      S_ITER:   if (r_iter == 5'd31) w_state_next = S_RESULT;
      S_RESULT: w_state_next = S_DONE;
      S_DONE:   w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_iter    <= '0;
      r_mcand   <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_sign_a  <= 1'b0;
      r_sign_b  <= 1'b0;
      r_neg     <= 1'b0;
      r_is_high <= 1'b0;
      r_rd      <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_iter <= '0;
          if (w_start) begin
            r_mcand   <= bus.d_rs1_i;
            r_lo      <= w_zero_op ? '0 : bus.d_rs2_i;
            r_hi      <= '0;
            r_sign_a  <= w_sign_a;
            r_sign_b  <= w_sign_b;
            r_neg     <= w_zero_op ? 1'b0 : (w_sign_a ^ w_sign_b);
            r_is_high <= (bus.d_fun_i != 3'd0);
          end
        end
        S_NEG_A: if (r_sign_a) r_mcand <= -r_mcand;
        S_NEG_B: if (r_sign_b) r_lo <= -r_lo;
        S_ITER: begin
          r_hi   <= w_sum[32:1];
          r_lo   <= {w_sum[0], r_lo[31:1]};
          r_iter <= r_iter + 5'd1;
        end
        // High word of the negated 64-bit product: the +1 only carries into
        // the high half when the low half is all zeros.
        S_RESULT: begin
          if (!r_is_high)  r_rd <= r_lo;
          else if (r_neg)  r_rd <= ~r_hi + {31'd0, (r_lo == '0)};
          else             r_rd <= r_hi;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_urv_multiply.sv
// Directed self-checking bench for urv_multiply (default and zero-bypass builds).
module tb_urv_multiply;

  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  urv_multiply_if bus ();

  urv_multiply dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef URV_MUL_ZERO_BYPASS_EN
  localparam int ZERO_LAT = 2;
`else
  localparam int ZERO_LAT = 36;
`endif

  // Issue one multiply; lat = cycles from the start edge until stall_req drops.
  task automatic do_op(input logic [2:0] fun, input logic [31:0] a, input logic [31:0] b,
                       input int kill_at, output logic [31:0] res, output int lat,
                       output logic pre_stall);
    @(negedge clk);
    bus.d_fun_i         = fun;
    bus.d_rs1_i         = a;
    bus.d_rs2_i         = b;
    bus.d_valid_i       = 1'b1;
    bus.d_is_multiply_i = 1'b1;
    #1 pre_stall = bus.x_stall_req_o;
    @(posedge clk);
    #1;
    bus.d_valid_i       = 1'b0;
    bus.d_is_multiply_i = 1'b0;
    bus.d_rs1_i         = $urandom;
    bus.d_rs2_i         = $urandom;
    bus.d_fun_i         = 3'($urandom);
    lat = 0;
    while (lat < 100) begin
      @(negedge clk);
      lat++;
      if (lat == kill_at) begin
        bus.x_kill_i  = 1'b1;
        bus.x_stall_i = 1'b1;
      end
      if (!bus.x_stall_req_o) break;
    end
    res = bus.x_rd_o;
    bus.x_kill_i  = 1'b0;
    bus.x_stall_i = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.x_stall_i = 1'b0; bus.x_kill_i = 1'b0; bus.d_valid_i = 1'b0;
    bus.d_is_multiply_i = 1'b0; bus.d_rs1_i = '0; bus.d_rs2_i = '0; bus.d_fun_i = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (bus.x_rd_o !== 32'h0) begin
      n_fail++; $display("FAIL reset_rd: got %h expected %h", bus.x_rd_o, 32'h0);
    end
    n_checks++;
    if (bus.x_stall_req_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_stall: got %b expected 0", bus.x_stall_req_o);
    end
    rst = 1'b0;
  endtask

  task automatic test_mul_basic;
    logic [31:0] res; int lat; logic pre;
    do_op(3'd0, 32'd7, 32'd6, 0, res, lat, pre);
    n_checks++;
    if (pre !== 1'b1) begin n_fail++; $display("FAIL mul_pre_stall: got %b expected 1", pre); end
    n_checks++;
    if (lat !== 36) begin n_fail++; $display("FAIL mul_latency: got %0d expected 36", lat); end
    n_checks++;
    if (res !== 32'h0000002A) begin n_fail++; $display("FAIL mul_7x6: got %h expected %h", res, 32'h2A); end
  endtask

  task automatic test_signed;
    logic [2:0]  fun [5] = '{3'd1, 3'd0, 3'd1, 3'd3, 3'd2};
    logic [31:0] va  [5] = '{32'hFFFFFFFD, 32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] vb  [5] = '{32'd5, 32'd5, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] exp [5] = '{32'hFFFFFFFF, 32'hFFFFFFF1, 32'h40000000, 32'hFFFFFFFE, 32'hFFFFFFFF};
    logic [31:0] res; int lat; logic pre;
    for (int i = 0; i < 5; i++) begin
      do_op(fun[i], va[i], vb[i], 0, res, lat, pre);
      n_checks++;
      if (res !== exp[i]) begin
        n_fail++; $display("FAIL signed_%0d result: got %h expected %h", i, res, exp[i]);
      end
      n_checks++;
      if (lat !== 36) begin
        n_fail++; $display("FAIL signed_%0d latency: got %0d expected 36", i, lat);
      end
    end
  endtask

  task automatic test_kill_busy;
    logic [31:0] res; int lat; logic pre;
    do_op(3'd3, 32'h00010000, 32'h00030000, 5, res, lat, pre);
    n_checks++;
    if (res !== 32'h00000003) begin n_fail++; $display("FAIL kill_busy_result: got %h expected %h", res, 32'h3); end
    n_checks++;
    if (lat !== 36) begin n_fail++; $display("FAIL kill_busy_latency: got %0d expected 36", lat); end
  endtask

  task automatic test_kill_idle;
    @(negedge clk);
    bus.d_fun_i = 3'd0; bus.d_rs1_i = 32'd3; bus.d_rs2_i = 32'd4;
    bus.d_valid_i = 1'b1; bus.d_is_multiply_i = 1'b1; bus.x_kill_i = 1'b1;
    #1;
    n_checks++;
    if (bus.x_stall_req_o !== 1'b0) begin n_fail++; $display("FAIL kill_idle_req: got %b expected 0", bus.x_stall_req_o); end
    @(posedge clk); #1;
    bus.d_valid_i = 1'b0; bus.d_is_multiply_i = 1'b0; bus.x_kill_i = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.x_stall_req_o !== 1'b0) begin n_fail++; $display("FAIL kill_idle_busy: got %b expected 0", bus.x_stall_req_o); end
    n_checks++;
    if (bus.x_rd_o !== 32'h00000003) begin n_fail++; $display("FAIL kill_idle_rd: got %h expected %h", bus.x_rd_o, 32'h3); end
  endtask

  task automatic test_reset_mid;
    logic [31:0] res; int lat; logic pre;
    @(negedge clk);
    bus.d_fun_i = 3'd3; bus.d_rs1_i = 32'h00010000; bus.d_rs2_i = 32'h00010000;
    bus.d_valid_i = 1'b1; bus.d_is_multiply_i = 1'b1;
    @(posedge clk); #1;
    bus.d_valid_i = 1'b0; bus.d_is_multiply_i = 1'b0;
    repeat (9) @(negedge clk);
    n_checks++;
    if (bus.x_stall_req_o !== 1'b1) begin n_fail++; $display("FAIL rstmid_busy: got %b expected 1", bus.x_stall_req_o); end
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.x_rd_o !== 32'h0) begin n_fail++; $display("FAIL rstmid_rd: got %h expected %h", bus.x_rd_o, 32'h0); end
    n_checks++;
    if (bus.x_stall_req_o !== 1'b0) begin n_fail++; $display("FAIL rstmid_stall: got %b expected 0", bus.x_stall_req_o); end
    rst = 1'b0;
    do_op(3'd3, 32'h00010000, 32'h00010000, 0, res, lat, pre);
    n_checks++;
    if (res !== 32'h00000001) begin n_fail++; $display("FAIL rstmid_fresh: got %h expected %h", res, 32'h1); end
    n_checks++;
    if (lat !== 36) begin n_fail++; $display("FAIL rstmid_fresh_lat: got %0d expected 36", lat); end
  endtask

  task automatic test_zero;
    logic [31:0] res; int lat; logic pre;
    do_op(3'd1, 32'h0, 32'h12345678, 0, res, lat, pre);
    n_checks++;
    if (res !== 32'h0) begin n_fail++; $display("FAIL zero_result: got %h expected %h", res, 32'h0); end
    n_checks++;
    if (lat !== ZERO_LAT) begin n_fail++; $display("FAIL zero_latency: got %0d expected %0d", lat, ZERO_LAT); end
  endtask

  task automatic test_hold;
    logic [31:0] res; int lat; logic pre;
    do_op(3'd0, 32'd100, 32'd3, 0, res, lat, pre);
    repeat (6) @(negedge clk);
    n_checks++;
    if (bus.x_rd_o !== 32'd300) begin n_fail++; $display("FAIL hold_rd: got %h expected %h", bus.x_rd_o, 32'd300); end
  endtask

  initial begin
    test_reset();
    test_mul_basic();
    test_signed();
    test_kill_busy();
    test_kill_idle();
    test_reset_mid();
    test_zero();
    test_hold();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
